// File: rtl/cnn_pool_pkg.sv
// Shared types and helpers for the CNN pooling stage.
// No logic of its own; the helpers are pure functions.
// No flow control; imported by max_lane and max_pool_acc.
// Contents:
//   pool_state_t : accumulator FSM states
//   LANE_MAX_W   : widest lane that lane_max can compare
//   cnt_w        : width of a beat counter that must hold 0..win
//   lane_max     : max of two pre-extended lane values
package cnn_pool_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        STALL = 1'b1
    } pool_state_t;

    // Lanes are sign- or zero-extended to this width before comparing.
    // That lets one function serve every N up to 64.
    localparam int LANE_MAX_W = 64;

    function automatic int cnt_w(input int win);
        return $clog2(win + 1);
    endfunction

    // On a tie this returns a, so the running maximum keeps its value.
    function automatic logic [LANE_MAX_W-1:0] lane_max(
        input logic [LANE_MAX_W-1:0] a,
        input logic [LANE_MAX_W-1:0] b,
        input logic                  signed_mode
    );
        logic b_gt;
        b_gt = signed_mode ? ($signed(b) > $signed(a)) : (b > a);
        return b_gt ? b : a;
    endfunction

endpackage

// File: rtl/max_pool_acc_max_lane.sv
// Per-lane compare/select for the pooling accumulator.
// Purely combinational, zero latency.
// No flow control; the parent decides when y is registered.
// Ports:
//   a     : current running maximum for this lane
//   b     : incoming beat for this lane
//   first : first beat of a window; y = b with no compare
//   y     : next running maximum
module max_lane
    import cnn_pool_pkg::*;
#(
    parameter int N      = 16,
    parameter bit SIGNED = 1'b1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         first,
    output logic [N-1:0] y
);

    logic [LANE_MAX_W-1:0] a_ext;
    logic [LANE_MAX_W-1:0] b_ext;
    logic [LANE_MAX_W-1:0] m_ext;
    logic                  take_b;

    always_comb begin
        if (SIGNED) begin
            a_ext = LANE_MAX_W'($signed(a));
            b_ext = LANE_MAX_W'($signed(b));
        end else begin
            a_ext = LANE_MAX_W'(a);
            b_ext = LANE_MAX_W'(b);
        end
        m_ext = lane_max(a_ext, b_ext, SIGNED);
        // lane_max keeps a on ties.
        // Select the narrow operand rather than truncating m_ext.
        take_b = first | (m_ext != a_ext);
        y      = take_b ? b : a;
    end

endmodule

// File: rtl/max_pool_acc.sv
// Streaming multi-lane max-pool: WIN beats in, one beat of per-lane maxima out.
// The result appears on data_out one cycle after the closing beat is accepted.
// Only the closing beat stalls, and only while an unread result sits in data_out.
// Ports:
//   clk, master_rst_n         : clock, async active-low reset
//   ce                        : input-side enable (forces in_ready low when 0)
//   clear                     : sync flush of partial window and output register
//   in_valid/in_ready/data_in : input beat handshake, lane c at [c*N +: N]
//   out_valid/out_ready/data_out : result handshake, lane c at [c*N +: N]
//   busy                      : a partial window is in progress
module max_pool_acc
    import cnn_pool_pkg::*;
#(
    parameter int N      = 16,
    parameter int CH     = 4,
    parameter int WIN    = 4,
    parameter bit SIGNED = 1'b1
) (
    input  logic          clk,
    input  logic          master_rst_n,
    input  logic          ce,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CH*N-1:0] data_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CH*N-1:0] data_out,
    output logic          busy
);

    localparam int CW = cnt_w(WIN);

    logic [CW-1:0]   count;
    logic [CH*N-1:0] acc;
    logic [CH*N-1:0] acc_nxt;
    pool_state_t     state;

    logic first_beat;
    logic last_beat;
    logic accept;
    logic out_fire;

    assign first_beat = (count == '0);
    assign last_beat  = (count == CW'(WIN - 1));
    assign out_fire   = out_valid & out_ready;

    // The closing beat waits only if data_out still holds an unread result.
    // A same-cycle out_fire frees the register, so there is no bubble.
    assign in_ready = ce & ~(last_beat & out_valid & ~out_ready);
    assign accept   = in_valid & in_ready;
    assign busy     = ~first_beat;

    for (genvar c = 0; c < CH; c++) begin : g_lane
        max_lane #(
            .N      (N),
            .SIGNED (SIGNED)
        ) u_max_lane (
            .a     (acc[c*N +: N]),
            .b     (data_in[c*N +: N]),
            .first (first_beat),
            .y     (acc_nxt[c*N +: N])
        );
    end

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            count     <= '0;
            acc       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            state     <= ACCUM;
        end else if (clear) begin
            count     <= '0;
            acc       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            state     <= ACCUM;
        end else begin
            if (accept) begin
                acc <= acc_nxt;
                if (last_beat) begin
                    count    <= '0;
                    data_out <= acc_nxt;
                end else begin
                    count <= CW'(count + 1'b1);
                end
            end

            if (accept && last_beat) begin
                out_valid <= 1'b1;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            // STALL tracks a closing beat that is blocked by a full output.
            case (state)
                ACCUM: begin
                    if (ce && in_valid && last_beat && out_valid && !out_ready) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (out_fire) begin
                        state <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_max_pool_acc.sv
module tb_max_pool_acc;

    localparam int N   = 16;
    localparam int CH  = 4;
    localparam int WIN = 4;
    localparam int W   = CH * N;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ce;
    logic         clear;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] data_in;

    logic         in_ready_s,  out_valid_s,  busy_s;
    logic [W-1:0] data_out_s;
    logic         in_ready_u,  out_valid_u,  busy_u;
    logic [W-1:0] data_out_u;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    max_pool_acc #(.N(N), .CH(CH), .WIN(WIN), .SIGNED(1'b1)) dut (
        .clk          (clk),
        .master_rst_n (rst_n),
        .ce           (ce),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready_s),
        .data_in      (data_in),
        .out_valid    (out_valid_s),
        .out_ready    (out_ready),
        .data_out     (data_out_s),
        .busy         (busy_s)
    );

    max_pool_acc #(.N(N), .CH(CH), .WIN(WIN), .SIGNED(1'b0)) dut_u (
        .clk          (clk),
        .master_rst_n (rst_n),
        .ce           (ce),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready_u),
        .data_in      (data_in),
        .out_valid    (out_valid_u),
        .out_ready    (out_ready),
        .data_out     (data_out_u),
        .busy         (busy_u)
    );

    // Reference model: the beats accepted so far in the open window,
    // plus the last completed result for each compare mode.
    logic [W-1:0] wq[$];
    bit           m_ov;
    logic [W-1:0] m_dout_s;
    logic [W-1:0] m_dout_u;

    function automatic logic [W-1:0] pack(input logic [N-1:0] l0, input logic [N-1:0] l1,
                                          input logic [N-1:0] l2, input logic [N-1:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    function automatic logic [W-1:0] win_max(input bit sgn);
        logic [W-1:0] r;
        logic [N-1:0] v;
        logic [N-1:0] m;
        bit           gt;
        r = wq[0];
        for (int i = 1; i < wq.size(); i++) begin
            for (int c = 0; c < CH; c++) begin
                v  = wq[i][c*N +: N];
                m  = r[c*N +: N];
                gt = sgn ? ($signed(v) > $signed(m)) : (v > m);
                if (gt) r[c*N +: N] = v;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        wq.delete();
        m_ov     = 1'b0;
        m_dout_s = '0;
        m_dout_u = '0;
    endtask

    function automatic bit model_rdy();
        return ce && !(wq.size() == WIN - 1 && m_ov && !out_ready);
    endfunction

    // Advance the model by one rising edge, using the inputs of that edge.
    task automatic model_step();
        bit closing;
        if (!rst_n || clear) begin
            model_reset();
            return;
        end
        closing = 1'b0;
        if (in_valid && model_rdy()) begin
            wq.push_back(data_in);
            if (wq.size() == WIN) begin
                m_dout_s = win_max(1'b1);
                m_dout_u = win_max(1'b0);
                wq.delete();
                closing = 1'b1;
            end
        end
        if (closing) m_ov = 1'b1;
        else if (m_ov && out_ready) m_ov = 1'b0;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("in_ready_s",  W'(in_ready_s),  W'(model_rdy()));
        chk("out_valid_s", W'(out_valid_s), W'(m_ov));
        chk("busy_s",      W'(busy_s),      W'(wq.size() != 0));
        chk("data_out_s",  data_out_s,      m_dout_s);
        chk("in_ready_u",  W'(in_ready_u),  W'(model_rdy()));
        chk("out_valid_u", W'(out_valid_u), W'(m_ov));
        chk("busy_u",      W'(busy_u),      W'(wq.size() != 0));
        chk("data_out_u",  data_out_u,      m_dout_u);
    endtask

    // Inputs are driven at the falling edge; outputs are compared 1 time unit later.
    task automatic tick();
        #1 check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic beat(input logic [W-1:0] d);
        in_valid = 1'b1;
        data_in  = d;
        tick();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        tick();
    endtask

    logic [W-1:0] rnd;
    logic [W-1:0] exp_w1;
    int           pulses;

    initial begin
        rst_n     = 1'b0;
        ce        = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        model_reset();

        // Reset state
        #1;
        chk("rst_out_valid", W'(out_valid_s), W'(0));
        chk("rst_busy",      W'(busy_s),      W'(0));
        chk("rst_data_out",  data_out_s,      '0);
        @(negedge clk);
        tick();
        rst_n     = 1'b1;
        ce        = 1'b1;
        out_ready = 1'b1;

        // Lane0 3,-7,12,5 ; lane1 -100,-3,-50,-9
        rnd = {$urandom, $urandom};
        beat(pack(16'd3,  16'hFF9C, rnd[15:0],  rnd[31:16]));
        beat(pack(16'hFFF9, 16'hFFFD, rnd[47:32], rnd[63:48]));
        rnd = {$urandom, $urandom};
        beat(pack(16'd12, 16'hFFCE, rnd[15:0],  rnd[31:16]));
        beat(pack(16'd5,  16'hFFF7, rnd[47:32], rnd[63:48]));
        in_valid = 1'b0;
        chk("t1_out_valid",   W'(out_valid_s),       W'(1));
        chk("t1_lane0",       W'(data_out_s[15:0]),  W'(16'd12));
        chk("t2_lane1_sgn",   W'(data_out_s[31:16]), W'(16'hFFFD));
        // Unsigned: 0xFFF9 tops lane0; 0xFFFD is the largest lane1 pattern too.
        chk("t2_lane0_uns",   W'(data_out_u[15:0]),  W'(16'hFFF9));
        chk("t2_lane1_uns",   W'(data_out_u[31:16]), W'(16'hFFFD));
        chk("t1_model_lane0", W'(m_dout_s[15:0]),    W'(16'd12));
        idle();

        // Back-to-back windows, no bubbles
        pulses = 0;
        for (int i = 0; i < 3 * WIN; i++) begin
            beat({$urandom, $urandom});
            chk("t3_in_ready", W'(in_ready_s), W'(1));
            if (out_valid_s) pulses++;
        end
        chk("t3_pulses", W'(pulses), W'(3));
        idle();

        // Output full when window 2 closes
        out_ready = 1'b0;
        for (int i = 0; i < WIN; i++) beat({$urandom, $urandom});
        exp_w1 = m_dout_s;
        for (int i = 0; i < WIN - 1; i++) beat({$urandom, $urandom});
        data_in = {$urandom, $urandom};
        #1 chk("t4_in_ready_stall", W'(in_ready_s), W'(1'b0));
        tick();
        tick();
        chk("t4_hold_valid", W'(out_valid_s), W'(1));
        chk("t4_hold_data",  data_out_s,      exp_w1);
        chk("t4_busy",       W'(busy_s),      W'(1));
        out_ready = 1'b1;
        #1 chk("t4_in_ready_release", W'(in_ready_s), W'(1));
        tick();
        chk("t4_w2_valid", W'(out_valid_s), W'(1));
        idle();

        // ce low mid-window
        beat(pack(16'd1, 16'd1, 16'd1, 16'd1));
        beat(pack(16'd4, 16'd4, 16'd4, 16'd4));
        ce = 1'b0;
        in_valid = 1'b1;
        data_in  = pack(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 5; i++) begin
            #1 chk("t5_in_ready", W'(in_ready_s), W'(0));
            chk("t5_busy", W'(busy_s), W'(1));
            tick();
        end
        ce = 1'b1;
        beat(pack(16'd2, 16'd2, 16'd2, 16'd2));
        out_ready = 1'b0;
        beat(pack(16'd3, 16'd3, 16'd3, 16'd3));
        in_valid = 1'b0;
        chk("t5_max", data_out_s, pack(16'd4, 16'd4, 16'd4, 16'd4));

        // clear with output full and 3 beats pending, then reset mid-window
        for (int i = 0; i < 3; i++) beat(pack(16'd9, 16'd9, 16'd9, 16'd9));
        clear = 1'b1;
        beat(pack(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF));
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t6_clr_valid", W'(out_valid_s), W'(0));
        chk("t6_clr_busy",  W'(busy_s),      W'(0));
        chk("t6_clr_data",  data_out_s,      '0);
        out_ready = 1'b1;
        beat(pack(16'd100, 16'd100, 16'd100, 16'd100));
        beat(pack(16'd100, 16'd100, 16'd100, 16'd100));
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_busy",  W'(busy_s),      W'(0));
        chk("t6_rst_valid", W'(out_valid_s), W'(0));
        chk("t6_rst_data",  data_out_s,      '0);
        tick();
        rst_n = 1'b1;
        beat(pack(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        beat(pack(16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE));
        beat(pack(16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFD));
        beat(pack(16'hFFFC, 16'hFFFC, 16'hFFFC, 16'hFFFC));
        in_valid = 1'b0;
        chk("t6_fresh_valid", W'(out_valid_s), W'(1));
        chk("t6_fresh_max",   data_out_s,      {W{1'b1}});
        idle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ce        = ($urandom_range(0, 9) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            clear     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0)
                data_in = pack(16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                               16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)));
            else
                data_in = {$urandom, $urandom};
            tick();
        end
        clear    = 1'b0;
        in_valid = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
